// File: rtl/axi_ram_fifo_bist_pkg.sv
// rtl/axi_ram_fifo_bist_pkg.sv - shared state encoding and lane width for the FIFO BIST
package axi_ram_fifo_bist_pkg;

    localparam int LANE_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TX      = 2'd1,
        ST_WAIT_RX = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/axi_ram_fifo_bist_pattern.sv
// rtl/axi_ram_fifo_bist_pattern.sv - word index to test pattern (lane k = index + k)
module axi_ram_fifo_bist_pattern
    import axi_ram_fifo_bist_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int COUNT_W = 32
) (
    input  logic [COUNT_W-1:0] index_i,
    output logic [DATA_W-1:0]  pattern_o
);

    logic [LANE_W-1:0] base;

    always_comb begin
        base = '0;
        for (int b = 0; b < COUNT_W && b < LANE_W; b++) begin
            base[b] = index_i[b];
        end
        pattern_o = '0;
        for (int k = 0; k < DATA_W / LANE_W; k++) begin
            pattern_o[k*LANE_W +: LANE_W] = base + LANE_W'(k);
        end
    end

endmodule

// File: rtl/axi_ram_fifo_bist.sv
// rtl/axi_ram_fifo_bist.sv - stream generator/checker BIST around an external FIFO
// Optional cycle counter: define AXI_RAM_FIFO_BIST_CYCLE_COUNT_EN.
module axi_ram_fifo_bist
    import axi_ram_fifo_bist_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int COUNT_W = 32,
    parameter int PKT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [COUNT_W-1:0] num_words,
    input  logic [PKT_W-1:0]   pkt_words,
    output logic [DATA_W-1:0]  m_tdata,
    output logic               m_tlast,
    output logic               m_tvalid,
    input  logic               m_tready,
    input  logic [DATA_W-1:0]  s_tdata,
    input  logic               s_tlast,
    input  logic               s_tvalid,
    output logic               s_tready,
    output logic               running,
    output logic               done,
    output logic               error,
    output logic [COUNT_W-1:0] tx_count,
    output logic [COUNT_W-1:0] rx_count,
    output logic [COUNT_W-1:0] err_count,
    output logic [COUNT_W-1:0] cycle_count
);

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] tx_cnt_q, rx_cnt_q, err_cnt_q, num_words_q;
    logic [PKT_W-1:0]   pkt_words_q, tx_pos_q, rx_pos_q;
    logic               cont_q, stop_q, error_q, s_tready_q;

    logic [DATA_W-1:0]  tx_pattern, rx_pattern;
    logic               start_ok, m_hs, s_hs;
    logic               tx_last_pkt, tx_end_word, tx_last;
    logic               rx_last_pkt, rx_last_exp, rx_bad;

    axi_ram_fifo_bist_pattern #(.DATA_W(DATA_W), .COUNT_W(COUNT_W)) u_tx_pattern (
        .index_i   (tx_cnt_q),
        .pattern_o (tx_pattern)
    );

    axi_ram_fifo_bist_pattern #(.DATA_W(DATA_W), .COUNT_W(COUNT_W)) u_rx_pattern (
        .index_i   (rx_cnt_q),
        .pattern_o (rx_pattern)
    );

    assign start_ok    = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign m_hs        = (state_q == ST_TX) && m_tready;
    assign s_hs        = s_tvalid && s_tready_q;

    // The num_words boundary only applies to bounded runs; continuous runs end on packets.
    assign tx_last_pkt = (tx_pos_q == pkt_words_q - PKT_W'(1));
    assign tx_end_word = !cont_q && (tx_cnt_q == num_words_q - COUNT_W'(1));
    assign tx_last     = tx_last_pkt || tx_end_word;

    assign rx_last_pkt = (rx_pos_q == pkt_words_q - PKT_W'(1));
    assign rx_last_exp = rx_last_pkt || (!cont_q && (rx_cnt_q == num_words_q - COUNT_W'(1)));
    assign rx_bad      = (state_q == ST_IDLE) || (state_q == ST_DONE)
                      || (s_tdata != rx_pattern) || (s_tlast != rx_last_exp);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = (continuous || num_words != '0) ? ST_TX : ST_WAIT_RX;
                end
            end
            ST_TX: begin
                if (m_hs && (cont_q ? (tx_last_pkt && (stop_q || stop)) : tx_end_word)) begin
                    state_d = ST_WAIT_RX;
                end
            end
            ST_WAIT_RX: begin
                if (rx_cnt_q == tx_cnt_q) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
            err_cnt_q   <= '0;
            num_words_q <= '0;
            pkt_words_q <= PKT_W'(1);
            tx_pos_q    <= '0;
            rx_pos_q    <= '0;
            cont_q      <= 1'b0;
            stop_q      <= 1'b0;
            error_q     <= 1'b0;
            s_tready_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_tready_q <= 1'b1;
            if (start_ok) begin
                tx_cnt_q    <= '0;
                rx_cnt_q    <= '0;
                err_cnt_q   <= '0;
                error_q     <= 1'b0;
                tx_pos_q    <= '0;
                rx_pos_q    <= '0;
                stop_q      <= 1'b0;
                num_words_q <= num_words;
                pkt_words_q <= (pkt_words == '0) ? PKT_W'(1) : pkt_words;
                cont_q      <= continuous;
            end else begin
                if (m_hs) begin
                    tx_cnt_q <= tx_cnt_q + COUNT_W'(1);
                    tx_pos_q <= tx_last_pkt ? '0 : tx_pos_q + PKT_W'(1);
                end
                if (stop && state_q == ST_TX) begin
                    stop_q <= 1'b1;
                end
                if (s_hs) begin
                    rx_cnt_q <= rx_cnt_q + COUNT_W'(1);
                    rx_pos_q <= rx_last_pkt ? '0 : rx_pos_q + PKT_W'(1);
                    if (rx_bad) begin
                        error_q <= 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_q <= err_cnt_q + COUNT_W'(1);
                        end
                    end
                end
            end
        end
    end

    assign m_tvalid  = (state_q == ST_TX);
    assign m_tdata   = m_tvalid ? tx_pattern : '0;
    assign m_tlast   = m_tvalid && tx_last;
    assign s_tready  = s_tready_q;
    assign running   = (state_q == ST_TX) || (state_q == ST_WAIT_RX);
    assign done      = (state_q == ST_DONE);
    assign error     = error_q;
    assign tx_count  = tx_cnt_q;
    assign rx_count  = rx_cnt_q;
    assign err_count = err_cnt_q;

`ifdef AXI_RAM_FIFO_BIST_CYCLE_COUNT_EN
    logic [COUNT_W-1:0] cycle_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
        end else if (start_ok) begin
            cycle_cnt_q <= '0;
        end else if (running && cycle_cnt_q != '1) begin
            cycle_cnt_q <= cycle_cnt_q + COUNT_W'(1);
        end
    end

    assign cycle_count = cycle_cnt_q;
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_axi_ram_fifo_bist.sv
// tb/tb_axi_ram_fifo_bist.sv - scoreboard bench with a behavioural loopback FIFO
module tb_axi_ram_fifo_bist;

    localparam int DATA_W  = 64;
    localparam int COUNT_W = 32;
    localparam int PKT_W   = 16;
    localparam int LANES   = DATA_W / 32;

    logic               clk = 1'b0;
    logic               rst_n, start, stop, continuous;
    logic [COUNT_W-1:0] num_words;
    logic [PKT_W-1:0]   pkt_words;
    logic [DATA_W-1:0]  m_tdata, s_tdata;
    logic               m_tlast, m_tvalid, m_tready;
    logic               s_tlast, s_tvalid, s_tready;
    logic               running, done, error;
    logic [COUNT_W-1:0] tx_count, rx_count, err_count, cycle_count;

    always #5 clk = ~clk;

    axi_ram_fifo_bist #(.DATA_W(DATA_W), .COUNT_W(COUNT_W), .PKT_W(PKT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .continuous  (continuous),
        .num_words   (num_words),
        .pkt_words   (pkt_words),
        .m_tdata     (m_tdata),
        .m_tlast     (m_tlast),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .s_tdata     (s_tdata),
        .s_tlast     (s_tlast),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .running     (running),
        .done        (done),
        .error       (error),
        .tx_count    (tx_count),
        .rx_count    (rx_count),
        .err_count   (err_count),
        .cycle_count (cycle_count)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } word_t;

    word_t             exp_q[$];
    word_t             fifo_q[$];
    logic [DATA_W-1:0] m_log[$];
    int                last_log[$];
    int                total = 0;
    int                bad = 0;
    bit                bp_mode = 1'b0;
    int                corrupt_idx = -1;
    int                rx_idx = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_word(input int unsigned n);
        logic [DATA_W-1:0] w;
        for (int k = 0; k < LANES; k++) begin
            w[k*32 +: 32] = 32'(n + k);
        end
        return w;
    endfunction

    task automatic push_expected(input int unsigned n, input int unsigned pkt, input bit cont);
        int unsigned pe;
        word_t w;
        pe = (pkt == 0) ? 1 : pkt;
        for (int unsigned i = 0; i < n; i++) begin
            w.data = model_word(i);
            w.last = ((i % pe) == pe - 1) || (!cont && i == n - 1);
            exp_q.push_back(w);
        end
    endtask

    // Behavioural FIFO between generator and checker, plus the scoreboard monitor.
    initial begin
        word_t e;
        word_t f;
        m_tready = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_tready = bp_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (fifo_q.size() > 0 && (!bp_mode || $urandom_range(0, 1) == 1)) begin
                s_tvalid = 1'b1;
                s_tdata  = fifo_q[0].data;
                s_tlast  = fifo_q[0].last;
                if (rx_idx == corrupt_idx) s_tdata[0] = ~s_tdata[0];
            end else begin
                s_tvalid = 1'b0;
                s_tdata  = '0;
                s_tlast  = 1'b0;
            end
            @(negedge clk);
            if (!rst_n) begin
                fifo_q.delete();
                exp_q.delete();
            end else begin
                if (start) begin
                    m_log.delete();
                    last_log.delete();
                    rx_idx = 0;
                end
                if (s_tvalid && s_tready) begin
                    fifo_q.delete(0);
                    rx_idx++;
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_tx_word: got word %0d expected none", m_log.size());
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_word", {m_tlast, m_tdata}, {e.last, e.data});
                    end
                    if (m_tlast) last_log.push_back(m_log.size());
                    m_log.push_back(m_tdata);
                    f.data = m_tdata;
                    f.last = m_tlast;
                    fifo_q.push_back(f);
                end
            end
        end
    end

    task automatic run_start(input int unsigned n, input int unsigned pkt, input bit cont);
        @(posedge clk);
        #1;
        num_words  = n;
        pkt_words  = PKT_W'(pkt);
        continuous = cont;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int i;
        i = 0;
        while (!done && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(name, done, 1);
    endtask

    task automatic check_end(input string tag, input int unsigned n, input int unsigned errs);
        check({tag, "_tx_count"}, tx_count, n);
        check({tag, "_rx_count"}, rx_count, n);
        check({tag, "_err_count"}, err_count, errs);
        check({tag, "_error"}, error, (errs != 0));
        check({tag, "_exp_left"}, exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, {running, done, error, m_tvalid, m_tlast, s_tready}, 0);
        check({tag, "_m_tdata"}, m_tdata, 0);
        check({tag, "_counts"}, {tx_count, rx_count, err_count}, 0);
        check({tag, "_cycle_count"}, cycle_count, 0);
    endtask

    initial begin
        int i;
        rst_n      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        continuous = 1'b0;
        num_words  = '0;
        pkt_words  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Loopback, full rate
        bp_mode = 1'b0;
        push_expected(10, 4, 1'b0);
        run_start(10, 4, 1'b0);
        wait_done("loop_done", 200);
        check_end("loop", 10, 0);
        check("loop_tlast_cnt", last_log.size(), 3);
        if (last_log.size() == 3) begin
            check("loop_tlast_pos", {last_log[0][7:0], last_log[1][7:0], last_log[2][7:0]},
                  {8'd3, 8'd7, 8'd9});
        end

        // Random backpressure on both sides
        bp_mode = 1'b1;
        push_expected(1000, 7, 1'b0);
        run_start(1000, 7, 1'b0);
        wait_done("bp_done", 10000);
        check_end("bp", 1000, 0);
        check("bp_word5_lane1", (m_log.size() > 5) ? m_log[5][63:32] : 32'hdead_beef, 32'h6);
        bp_mode = 1'b0;

        // Continuous with stop mid-packet
        push_expected(64, 16, 1'b1);
        run_start(5, 16, 1'b1);
        i = 0;
        while (tx_count < 50 && i < 500) begin
            @(negedge clk);
            i++;
        end
        check("cont_reach_50", tx_count >= 50, 1);
        @(posedge clk);
        #1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        wait_done("cont_done", 500);
        check_end("cont", 64, 0);

        // Corrupted word 3 on the checker side
        corrupt_idx = 3;
        push_expected(8, 4, 1'b0);
        run_start(8, 4, 1'b0);
        wait_done("corrupt_done", 200);
        check_end("corrupt", 8, 1);
        corrupt_idx = -1;

        // num_words = 0
        run_start(0, 4, 1'b0);
        check("zero_c1", {done, m_tvalid, running}, 3'b001);
        @(posedge clk);
        #1;
        check("zero_c2", {done, m_tvalid, running, tx_count}, {3'b100, 32'd0});

        // Reset in the middle of TX, then restart
        push_expected(100, 8, 1'b0);
        run_start(100, 8, 1'b0);
        i = 0;
        while (tx_count != 20 && i < 500) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("rst_reach_20", tx_count, 20);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_expected(30, 5, 1'b0);
        run_start(30, 5, 1'b0);
        wait_done("restart_done", 500);
        check_end("restart", 30, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_ram_fifo_bist.md
AXI_RAM_FIFO_BIST -- requirements
Module: axi_ram_fifo_bist

Interface
REQ-001 SHALL have parameter DATA_W, default 64: stream data width in bits, a multiple of 32, from 32 to 512.
REQ-002 SHALL have parameter COUNT_W, default 32: width of the word, error and cycle counters.
REQ-003 SHALL have parameter PKT_W, default 16: width of the packet-size field.
REQ-004 SHALL have one clock and a synchronous, active-low reset.
- clk  in  1  sole clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
REQ-005 SHALL have control inputs:
- start  in  1  single-cycle pulse; begin a test
- stop  in  1  single-cycle pulse; end continuous mode
- continuous  in  1  ignore num_words; run until stop
- num_words  in  COUNT_W  words to send; 0 means none
- pkt_words  in  PKT_W  words per packet; 0 is treated as 1
REQ-006 SHALL have generator outputs into the FIFO:
- m_tdata  out  DATA_W
- m_tlast  out  1
- m_tvalid  out  1
- m_tready  in  1
REQ-007 SHALL have checker inputs from the FIFO:
- s_tdata  in  DATA_W
- s_tlast  in  1
- s_tvalid  in  1
- s_tready  out  1
REQ-008 SHALL have status outputs:
- running  out  1
- done  out  1
- error  out  1  sticky
- tx_count  out  COUNT_W
- rx_count  out  COUNT_W
- err_count  out  COUNT_W
- cycle_count  out  COUNT_W

Function
REQ-009 SHALL implement the states IDLE, TX, WAIT_RX and DONE.
REQ-010 SHALL, on start in IDLE or DONE: clear all counters and error in that same cycle, latch num_words, pkt_words and continuous, and enter TX on the next cycle.
REQ-011 SHALL ignore start while in TX or WAIT_RX.
REQ-012 SHALL hold m_tvalid=1 in TX and 0 in every other state.
- Data SHALL advance only on the m_tvalid & m_tready handshake.
- tx_count SHALL increment by 1 per handshake.
REQ-013 SHALL generate word n with 32-bit lane k (k=0 at the LSB) = n + k, modulo 2^32.
REQ-014 SHALL assert m_tlast on the last word of each pkt_words-word packet, and on word num_words-1 even if that packet is short.
REQ-015 SHALL leave TX for WAIT_RX:
- non-continuous: after handshake of word num_words-1;
- continuous: after the first handshake with m_tlast=1 following a stop pulse; stop is latched if it arrives mid-packet;
- num_words=0, non-continuous: directly to WAIT_RX with no words sent.
REQ-016 SHALL move WAIT_RX -> DONE when rx_count == tx_count; done=1 only in DONE.
REQ-017 SHALL drive s_tready=1 in all states except reset; rx_count SHALL increment on every s_tvalid handshake.
REQ-018 SHALL, on each received word, compare s_tdata against the REQ-013 pattern at index rx_count, and s_tlast against the REQ-014 rule.
- On mismatch: increment err_count (saturating) and set error.
- A word received in IDLE or DONE counts as an error.
REQ-019 SHALL assert running in TX and WAIT_RX.
REQ-020 SHALL wrap tx_count and rx_count at 2^COUNT_W; err_count SHALL saturate at all-ones.

Reset
REQ-021 SHALL, when rst_n=0 at a clock edge, set state IDLE, all counters 0, m_tvalid=0, m_tlast=0, m_tdata=0, s_tready=0, running/done/error=0.
REQ-022 SHALL abort a test in progress on reset mid-operation, with no further handshakes until a new start.

Configuration
REQ-023 SHALL, with AXI_RAM_FIFO_BIST_CYCLE_COUNT_EN defined, count cycle_count by 1 per clock while running (saturating), cleared on start.
- Without the macro, cycle_count SHALL be tied to 0 and no counter SHALL be synthesised.

Structure
REQ-024 SHALL place the state enum and the 32-bit lane width constant in the shared package axi_ram_fifo_bist_pkg.
REQ-025 SHALL use one sub-module, axi_ram_fifo_bist_pattern, shared by generator and checker: index in, DATA_W pattern out, combinational.

Verification
REQ-026 Bench SHALL cover:
- Loopback, m_tready=1, num_words=10, pkt_words=4, DATA_W=64 -> tlast on words 3, 7, 9; done; tx=rx=10; err_count=0.
- Random m_tready backpressure, num_words=1000, pkt_words=7 -> word 5 lane1 = 0x00000006; done; err_count=0.
- Continuous; stop pulse at tx_count=50, pkt_words=16 -> final tx_count=64; done.
- Checker fed word 3 with bit 0 flipped, num_words=8 -> err_count=1; error=1; done still asserts.
- num_words=0 -> no m_tvalid; done 2 cycles after start.
- rst_n=0 mid-TX at tx_count=20 -> all outputs 0 next cycle; restart succeeds with err_count=0.
